// File: rtl/pio_in_pkg.sv
// rtl/pio_in_pkg.sv - shared constants and helpers for the input PIO
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_DIR  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pio_in_debounce.sv
// rtl/pio_in_debounce.sv - single-bit two-flop synchroniser plus stability debouncer
module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable
);

    // Keep at least one counter bit so the bypass configuration stays legal.
    localparam int CNT_RAW = clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d     = din;
        s2_d     = s1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = s2_q;
        end else if (s2_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= RESET_VALUE;
            s2_q     <= RESET_VALUE;
            stable_q <= RESET_VALUE;
            cnt_q    <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/pio_in_irq.sv
// rtl/pio_in_irq.sv - debounced input PIO with sticky edge capture and maskable level irq
module pio_in_irq
    import pio_in_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d_q, stable_d_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] rise, fall, sel_edge;
    logic             wr_en;
    logic             unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .din    (in_port[i]),
            .stable (stable[i])
        );
    end

    assign rise = stable & ~stable_d_q;
    assign fall = ~stable & stable_d_q;

    if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
        assign sel_edge = fall;
    end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
        assign sel_edge = rise | fall;
    end else begin : g_rise
        assign sel_edge = rise;
    end

    assign wr_en        = chipselect & write;
    assign unused_wdata = ^writedata;

    always_comb begin
        stable_d_d = stable;
        mask_d     = mask_q;
        edge_d     = edge_q;
        if (wr_en && address == ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGE) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        // Applying the set after the clear keeps a coincident edge from being lost.
        edge_d = edge_d | sel_edge;
        irq_d  = |(edge_q & mask_q);

        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = stable;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
            default:   readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d_q <= RESET_VALUE;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            stable_d_q <= stable_d_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_irq.sv
// tb/tb_pio_in_irq.sv - directed self-checking bench for pio_in_irq
module tb_pio_in_irq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] in_port_w;

    logic [31:0] rd_main, rd_fall, rd_any, rd_w32;
    logic        irq_main, irq_fall, irq_any, irq_w32;

    int errors;
    int checks;

    pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_VALUE(4'h0)) u_main (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_main), .in_port(in_port), .irq(irq_main));

    pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'hA)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_fall), .in_port(in_port), .irq(irq_fall));

    pio_in_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_VALUE(4'h0)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_any), .in_port(in_port), .irq(irq_any));

    pio_in_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0), .RESET_VALUE(32'h0)) u_w32 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd_w32), .in_port(in_port_w), .irq(irq_w32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        tick(1);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write = 1'b0;
        writedata = '0; in_port = 4'h0; in_port_w = '0;
        tick(3);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: readdata=%h irq=%b, want 0/0", rd_main, irq_main);
        end
        reset = 1'b0;
        address = 2'd0; tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", rd_main);
        end
        checks++;
        if (rd_fall !== 32'h0000000A) begin
            errors++; $display("FAIL reset_value: got %h want 0000000a", rd_fall);
        end
        checks++;
        if (rd_w32 !== 32'h0) begin
            errors++; $display("FAIL reset_w32: got %h want 0", rd_w32);
        end
        address = 2'd2; tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL reset_mask: got %h want 0", rd_main);
        end
        address = 2'd3; tick(1);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++; $display("FAIL reset_edge: got %h irq=%b want 0/0", rd_main, irq_main);
        end
    endtask

    task automatic test_edge_irq;
        tick(10);
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h1);
        address = 2'd3;
        in_port = 4'h1;
        tick(7);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++; $display("FAIL edge_early: rd=%h irq=%b want 0/0", rd_main, irq_main);
        end
        tick(1);
        checks++;
        if (rd_main !== 32'h1 || irq_main !== 1'b1) begin
            errors++; $display("FAIL edge_set: rd=%h irq=%b want 1/1", rd_main, irq_main);
        end
        bus_write(2'd3, 32'h1);
        checks++;
        if (rd_main !== 32'h1 || irq_main !== 1'b1) begin
            errors++; $display("FAIL clear_pre: rd=%h irq=%b want 1/1", rd_main, irq_main);
        end
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_main !== 32'h0 || irq_main !== 1'b0) begin
            errors++; $display("FAIL clear_post: rd=%h irq=%b want 0/0", rd_main, irq_main);
        end
    endtask

    task automatic test_set_wins;
        in_port = 4'h3;
        tick(6);
        bus_write(2'd3, 32'h2);
        address = 2'd3;
        tick(1);
        checks++;
        if (rd_main !== 32'h2) begin
            errors++; $display("FAIL set_wins: edge_capture=%h want 2", rd_main);
        end
        tick(1);
        checks++;
        if (irq_main !== 1'b0) begin
            errors++; $display("FAIL mask_blocks: irq=%b want 0", irq_main);
        end
    endtask

    task automatic test_glitch;
        logic seen;
        in_port = 4'h0;
        tick(12);
        bus_write(2'd3, 32'hF);
        address = 2'd0;
        in_port = 4'h2;
        tick(3);
        in_port = 4'h0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (rd_main[1] !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL glitch_data: bit1 seen=%b want 0", seen);
        end
        address = 2'd3; tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL glitch_edge: edge_capture=%h want 0", rd_main);
        end
    endtask

    task automatic test_debounce_latency;
        address = 2'd0;
        in_port = 4'h1;
        tick(6);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL latency_early: rd=%h want 0", rd_main);
        end
        tick(1);
        checks++;
        if (rd_main !== 32'h1) begin
            errors++; $display("FAIL latency_exact: rd=%h want 1", rd_main);
        end
    endtask

    task automatic test_edge_types;
        in_port = 4'h0;
        tick(12);
        bus_write(2'd3, 32'hF);
        in_port = 4'h1;
        tick(12);
        address = 2'd3; tick(1);
        checks++;
        if (rd_fall !== 32'h0 || rd_any !== 32'h1 || rd_main !== 32'h1) begin
            errors++;
            $display("FAIL edge_type_rise: fall=%h any=%h rise=%h want 0/1/1", rd_fall, rd_any, rd_main);
        end
        bus_write(2'd3, 32'hF);
        in_port = 4'h0;
        tick(12);
        address = 2'd3; tick(1);
        checks++;
        if (rd_fall !== 32'h1 || rd_any !== 32'h1 || rd_main !== 32'h0) begin
            errors++;
            $display("FAIL edge_type_fall: fall=%h any=%h rise=%h want 1/1/0", rd_fall, rd_any, rd_main);
        end
    endtask

    task automatic test_bus_corners;
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'hFFFFFFFF);
        bus_write(2'd1, 32'hFFFFFFFF);
        address = 2'd0; tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL wr_addr0: data=%h want 0", rd_main);
        end
        address = 2'd1; tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL dir_read: got %h want 0", rd_main);
        end
        address = 2'd2; tick(1);
        checks++;
        if (rd_main !== 32'h1) begin
            errors++; $display("FAIL mask_kept: got %h want 1", rd_main);
        end
        address = 2'd3; tick(1);
        checks++;
        if (rd_main !== 32'h0) begin
            errors++; $display("FAIL edge_kept: got %h want 0", rd_main);
        end
        bus_write(2'd2, 32'hFFFFFFFF);
        address = 2'd2; tick(1);
        checks++;
        if (rd_main !== 32'h0000000F) begin
            errors++; $display("FAIL mask_upper: got %h want 0000000f", rd_main);
        end
        chipselect = 1'b0; write = 1'b1; writedata = 32'h0; address = 2'd2;
        tick(1);
        write = 1'b0;
        tick(1);
        checks++;
        if (rd_main !== 32'h0000000F) begin
            errors++; $display("FAIL cs_gate: got %h want 0000000f", rd_main);
        end
    endtask

    task automatic test_w32;
        address = 2'd0;
        in_port_w = 32'hDEADBEEF;
        tick(2);
        checks++;
        if (rd_w32 === 32'hDEADBEEF) begin
            errors++; $display("FAIL w32_early: got %h want not deadbeef", rd_w32);
        end
        tick(2);
        checks++;
        if (rd_w32 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL w32_data: got %h want deadbeef", rd_w32);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_edge_irq();
        test_set_wins();
        test_glitch();
        test_debounce_latency();
        test_edge_types();
        test_bus_corners();
        test_w32();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
